// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control unit: alusel codes, aluop classes, M-op funct3 and FSM states.
package alu_ctrl_pkg;

    localparam logic [3:0] SEL_AND  = 4'b0000;
    localparam logic [3:0] SEL_OR   = 4'b0001;
    localparam logic [3:0] SEL_ADD  = 4'b0010;
    localparam logic [3:0] SEL_PASS = 4'b0011;
    localparam logic [3:0] SEL_XOR  = 4'b0100;
    localparam logic [3:0] SEL_SUB  = 4'b0110;
    localparam logic [3:0] SEL_SLL  = 4'b1000;
    localparam logic [3:0] SEL_SRL  = 4'b1001;
    localparam logic [3:0] SEL_SRA  = 4'b1010;
    localparam logic [3:0] SEL_SLT  = 4'b1101;
    localparam logic [3:0] SEL_SLTU = 4'b1111;

    localparam logic [1:0] OP_MEM = 2'b00;
    localparam logic [1:0] OP_BR  = 2'b01;
    localparam logic [1:0] OP_R   = 2'b10;
    localparam logic [1:0] OP_I   = 2'b11;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_MUL  = 3'd1;
    localparam state_t ST_DIV  = 3'd2;
    localparam state_t ST_FIX  = 3'd3;
    localparam state_t ST_DONE = 3'd4;

endpackage

// File: rtl/alu_ctrl_mdu_iter.sv
// Iterative magnitude datapath: radix-2 shift-add multiply, restoring divide (ALU_CTRL_DIV_EN only).
// One step per cycle while run is high; done once XLEN steps have completed; no backpressure.
module mdu_iter #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef ALU_CTRL_DIV_EN
    input  logic              div,
`endif
    input  logic              run,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic              done,
    output logic [2*XLEN-1:0] acc
);

    localparam int CW = $clog2(XLEN) + 1;

    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] bq;
    logic [XLEN:0]   add_sum;

    assign done    = (cnt == CW'(XLEN));
    assign add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? bq : {XLEN{1'b0}})};

`ifdef ALU_CTRL_DIV_EN
    logic          div_q;
    logic [XLEN:0] trial;

    // Partial remainder shifted left one place, minus the divisor; bit XLEN set means borrow.
    assign trial = acc[2*XLEN-1:XLEN-1] - {1'b0, bq};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            bq  <= '0;
            acc <= '0;
`ifdef ALU_CTRL_DIV_EN
            div_q <= 1'b0;
`endif
        end else if (start) begin
            cnt <= '0;
            bq  <= b;
            acc <= {{XLEN{1'b0}}, a};
`ifdef ALU_CTRL_DIV_EN
            div_q <= div;
`endif
        end else if (run && !done) begin
            cnt <= cnt + 1'b1;
`ifdef ALU_CTRL_DIV_EN
            if (div_q)
                acc <= trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                   : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
                acc <= {add_sum, acc[XLEN-1:1]};
`else
            acc <= {add_sum, acc[XLEN-1:1]};
`endif
        end
    end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU select decoder plus M-extension sequencer (divide ops only when ALU_CTRL_DIV_EN is defined).
// alusel/m_op/illegal combinational; M result valid XLEN+2 edges after accept, held until out_ready.
module alu_ctrl_mdu import alu_ctrl_pkg::*; #(
    parameter int XLEN  = 32,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       aluop,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             funct7_0,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    output logic [SEL_W-1:0] alusel,
    output logic             m_op,
    output logic             illegal,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result
);

    state_t            state;
    logic              accept, a_sgn, b_sgn, a_neg, b_neg, neg_q, iter_start, iter_done;
    logic [2:0]        f3_q;
    logic [XLEN-1:0]   a_mag, b_mag, fix_res;
    logic [2*XLEN-1:0] acc, prod;

    assign m_op = (aluop == OP_R) && funct7_0;

    always_comb begin
        alusel  = SEL_W'(SEL_ADD);
        illegal = 1'b0;
        case (aluop)
            OP_MEM: alusel = SEL_W'(SEL_ADD);
            OP_BR:  alusel = SEL_W'(SEL_SUB);
            default: begin
                case (funct3)
                    3'b000:  alusel = (aluop == OP_R && funct7_5) ? SEL_W'(SEL_SUB) : SEL_W'(SEL_ADD);
                    3'b001:  alusel = SEL_W'(SEL_SLL);
                    3'b010:  alusel = SEL_W'(SEL_SLT);
                    3'b011:  alusel = SEL_W'(SEL_SLTU);
                    3'b100:  alusel = SEL_W'(SEL_XOR);
                    3'b101:  alusel = funct7_5 ? SEL_W'(SEL_SRA) : SEL_W'(SEL_SRL);
                    3'b110:  alusel = SEL_W'(SEL_OR);
                    default: alusel = SEL_W'(SEL_AND);
                endcase
                if (aluop == OP_R && funct7_5 && funct3 != 3'b000 && funct3 != 3'b101)
                    illegal = 1'b1;
            end
        endcase
        if (m_op) begin
            alusel = SEL_W'(SEL_ADD);
`ifndef ALU_CTRL_DIV_EN
            if (funct3[2])
                illegal = 1'b1;
`endif
        end
    end

    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (funct3)
            F3_MULH, F3_DIV, F3_REM: begin
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            F3_MULHSU: a_sgn = 1'b1;
            default: ;
        endcase
    end

    assign a_neg     = a_sgn & op_a[XLEN-1];
    assign b_neg     = b_sgn & op_b[XLEN-1];
    assign a_mag     = a_neg ? -op_a : op_a;
    assign b_mag     = b_neg ? -op_b : op_b;
    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready && m_op && !illegal;

`ifdef ALU_CTRL_DIV_EN
    logic            neg_r, special, spec_hit, div_zero;
    logic [XLEN-1:0] spec_res;

    assign div_zero = (op_b == '0);
    assign spec_hit = funct3[2] && (div_zero ||
                      (a_sgn && op_a == {1'b1, {(XLEN-1){1'b0}}} && op_b == '1));
    assign iter_start = accept && !spec_hit;
`else
    assign iter_start = accept;
`endif

    mdu_iter #(.XLEN(XLEN)) u_iter (
        .clk   (clk),
        .rst   (rst),
        .start (iter_start),
`ifdef ALU_CTRL_DIV_EN
        .div   (funct3[2]),
`endif
        .run   (state == ST_MUL || state == ST_DIV),
        .a     (a_mag),
        .b     (b_mag),
        .done  (iter_done),
        .acc   (acc)
    );

    // Iteration ran on magnitudes; restore the sign and pick the half the op asked for.
    assign prod = neg_q ? -acc : acc;

    always_comb begin
        fix_res = prod[XLEN-1:0];
        case (f3_q)
            F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod[2*XLEN-1:XLEN];
`ifdef ALU_CTRL_DIV_EN
            F3_DIV, F3_DIVU: fix_res = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
            F3_REM, F3_REMU: fix_res = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
`endif
            default: ;
        endcase
`ifdef ALU_CTRL_DIV_EN
        if (special)
            fix_res = spec_res;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            f3_q       <= '0;
            neg_q      <= 1'b0;
            out_result <= '0;
`ifdef ALU_CTRL_DIV_EN
            neg_r    <= 1'b0;
            special  <= 1'b0;
            spec_res <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    f3_q  <= funct3;
                    neg_q <= a_neg ^ b_neg;
                    state <= ST_MUL;
`ifdef ALU_CTRL_DIV_EN
                    neg_r    <= a_neg;
                    special  <= spec_hit;
                    spec_res <= funct3[1] ? (div_zero ? op_a : '0) : (div_zero ? '1 : op_a);
                    if (funct3[2])
                        state <= spec_hit ? ST_FIX : ST_DIV;
`endif
                end
                ST_MUL, ST_DIV: if (iter_done) state <= ST_FIX;
                ST_FIX: begin
                    out_result <= fix_res;
                    state      <= ST_DONE;
                end
                ST_DONE: if (out_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Scoreboarded bench for alu_ctrl_mdu: directed decode vectors and M ops with hand-computed results.
module tb_alu_ctrl_mdu;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      aluop = 2'b00;
    logic [2:0]      funct3 = 3'b000;
    logic            funct7_5 = 1'b0;
    logic            funct7_0 = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [XLEN-1:0] op_a = '0;
    logic [XLEN-1:0] op_b = '0;
    logic [3:0]      alusel;
    logic            m_op;
    logic            illegal;
    logic            busy;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] out_result;

    alu_ctrl_mdu #(.XLEN(XLEN), .SEL_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .aluop      (aluop),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .funct7_0   (funct7_0),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .alusel     (alusel),
        .m_op       (m_op),
        .illegal    (illegal),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [XLEN-1:0] res;
        int              lat;
        int              acc;
        string           nm;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

`ifdef ALU_CTRL_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on each output transfer and watches the hold contract.
    int              rise_cyc = 0;
    logic            pv = 1'b0;
    logic [XLEN-1:0] pr = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            pv = 1'b0;
        end else begin
            if (out_valid && !pv) rise_cyc = cyc;
            if (out_valid && pv) check("hold_stable", out_result, pr);
            if (out_valid) check("in_ready_while_valid", in_ready, 0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got 0x%0h, required no output", out_result);
                end else begin
                    e = q.pop_front();
                    check(e.nm, out_result, e.res);
                    if (e.lat >= 0) check({e.nm, "_latency"}, 64'(rise_cyc - e.acc), 64'(e.lat));
                end
            end
            pv = out_valid;
            pr = out_result;
        end
    end

    task automatic dec(input logic [1:0] op, input logic [2:0] f3, input logic f75, input logic f70,
                       input logic [3:0] esel, input logic eill, input string nm);
        aluop = op; funct3 = f3; funct7_5 = f75; funct7_0 = f70; in_valid = 1'b0;
        #1;
        check({nm, "_alusel"}, alusel, esel);
        check({nm, "_illegal"}, illegal, eill);
        check({nm, "_m_op"}, m_op, (op == 2'b10) && f70);
    endtask

    task automatic issue(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] res, input int lat, input bit push, input string nm);
        exp_t e;
        int   n = 0;
        @(posedge clk); #1;
        aluop = 2'b10; funct3 = f3; funct7_5 = 1'b0; funct7_0 = 1'b1;
        op_a = a; op_b = b; in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL %s_accept: in_ready stayed 0, required 1", nm);
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (push) begin
                e.res = res; e.lat = lat; e.acc = cyc; e.nm = nm;
                q.push_back(e);
            end
        end
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL %s: %0d results outstanding, required 0", nm, q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_result", out_result, 0);
        rst = 1'b0;

        dec(2'b00, 3'b000, 1'b0, 1'b0, 4'b0010, 1'b0, "ld_add");
        dec(2'b01, 3'b000, 1'b0, 1'b0, 4'b0110, 1'b0, "br_sub");
        dec(2'b10, 3'b000, 1'b0, 1'b0, 4'b0010, 1'b0, "r_add");
        dec(2'b10, 3'b000, 1'b1, 1'b0, 4'b0110, 1'b0, "r_sub");
        dec(2'b10, 3'b001, 1'b0, 1'b0, 4'b1000, 1'b0, "r_sll");
        dec(2'b10, 3'b010, 1'b0, 1'b0, 4'b1101, 1'b0, "r_slt");
        dec(2'b10, 3'b011, 1'b0, 1'b0, 4'b1111, 1'b0, "r_sltu");
        dec(2'b10, 3'b100, 1'b0, 1'b0, 4'b0100, 1'b0, "r_xor");
        dec(2'b10, 3'b101, 1'b0, 1'b0, 4'b1001, 1'b0, "r_srl");
        dec(2'b10, 3'b101, 1'b1, 1'b0, 4'b1010, 1'b0, "r_sra");
        dec(2'b10, 3'b110, 1'b0, 1'b0, 4'b0001, 1'b0, "r_or");
        dec(2'b10, 3'b111, 1'b0, 1'b0, 4'b0000, 1'b0, "r_and");
        dec(2'b10, 3'b111, 1'b1, 1'b0, 4'b0000, 1'b1, "r_and_f7");
        dec(2'b11, 3'b000, 1'b1, 1'b0, 4'b0010, 1'b0, "i_addi_f7");
        dec(2'b11, 3'b101, 1'b1, 1'b0, 4'b1010, 1'b0, "i_srai");
        dec(2'b11, 3'b001, 1'b1, 1'b0, 4'b1000, 1'b0, "i_slli_f7");
        dec(2'b11, 3'b010, 1'b1, 1'b0, 4'b1101, 1'b0, "i_slti_f7");
        dec(2'b10, 3'b011, 1'b0, 1'b1, 4'b0010, 1'b0, "m_mulhu");
        dec(2'b10, 3'b100, 1'b0, 1'b1, 4'b0010, !DIV_EN, "m_div");

        // A valid R-type ALU op must not start the sequencer.
        @(posedge clk); #1;
        aluop = 2'b10; funct3 = 3'b000; funct7_5 = 1'b0; funct7_0 = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("non_m_busy", busy, 0);
        check("non_m_in_ready", in_ready, 1);

`ifndef ALU_CTRL_DIV_EN
        @(posedge clk); #1;
        aluop = 2'b10; funct3 = 3'b100; funct7_5 = 1'b0; funct7_0 = 1'b1;
        op_a = 32'd7; op_b = 32'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("div_off_busy", busy, 0);
        check("div_off_in_ready", in_ready, 1);
`endif

        issue(3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34, 1'b1, "mulh_m1x2");
        check("busy_after_accept", busy, 1);
        check("in_ready_after_accept", in_ready, 0);
        issue(3'b000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 34, 1'b1, "mul_min_sq");
        issue(3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 1'b1, "mulhu_min_sq");
        issue(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 1'b1, "mulh_min_sq");
        issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 1'b1, "mulhsu_m1");
        issue(3'b000, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 34, 1'b1, "mul_m3x5");
        issue(3'b001, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 34, 1'b1, "mulh_m3x5");
`ifdef ALU_CTRL_DIV_EN
        issue(3'b100, 32'd7,         32'd0,         32'hFFFF_FFFF, -1, 1'b1, "div_by_zero");
        issue(3'b110, 32'd7,         32'd0,         32'd7,         -1, 1'b1, "rem_by_zero");
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         -1, 1'b1, "rem_overflow");
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, -1, 1'b1, "div_overflow");
        issue(3'b101, 32'd100,       32'd7,         32'd14,        34, 1'b1, "divu_100_7");
        issue(3'b111, 32'd100,       32'd7,         32'd2,         34, 1'b1, "remu_100_7");
        issue(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 1'b1, "div_m7_2");
        issue(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 1'b1, "rem_m7_2");
`endif
        drain("drain_main");

        // Consumer stalls for 10 cycles while another M op is offered.
        out_ready = 1'b0;
        issue(3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 1'b1, "mulhu_held");
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("held_out_valid", out_valid, 1);
        aluop = 2'b10; funct3 = 3'b000; funct7_0 = 1'b1; op_a = 32'd2; op_b = 32'd2; in_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        check("no_second_accept", busy, 0);
        drain("drain_hold");

        // Reset in the middle of a multiply discards it.
        issue(3'b000, 32'd9, 32'd9, 32'd81, 34, 1'b0, "mul_aborted");
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_out_valid", out_valid, 0);
        check("midreset_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        issue(3'b000, 32'd3, 32'd5, 32'd15, 34, 1'b1, "mul_3x5_after_reset");
        drain("drain_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
